// File: rtl/rst_sequencer_if.sv
// Request/status bundle between the reset sequencer and its requesters.
// Requesters drive the master side; the sequencer owns the slave side.
interface rst_sequencer_if #(
   parameter int N_DOM = 3
);
   logic             req_in;
   logic             sw_req;
   logic             wdog_kick;
   logic [N_DOM-1:0] rst_out;
   logic             all_released;
   logic [2:0]       cause;
   logic [1:0]       state_dbg;

   // There is no ready: req_in is a raw level, while sw_req and wdog_kick are
   // single-cycle pulses. Each of these is taken on the clock edge that samples it.
   modport master (
      output req_in, sw_req, wdog_kick,
      input  rst_out, all_released, cause, state_dbg
   );

   modport slave (
      input  req_in, sw_req, wdog_kick,
      output rst_out, all_released, cause, state_dbg
   );
endinterface

// File: rtl/rst_sequencer.sv
// Central reset sequencer: holds N_DOM domain resets, then releases them in a staggered order.
// Define RST_WDOG_EN to build the watchdog, which raises cause 4 when wdog_kick stops.
module rst_sequencer #(
   parameter int N_DOM        = 3,
   parameter int DEBOUNCE_CYC = 16,
   parameter int HOLD_CYC     = 64,
   parameter int STAGGER_CYC  = 8,
   parameter int WDOG_CYC     = 1024
) (
   input  logic          clock,
   input  logic          reset,
   rst_sequencer_if.slave bus
);
   localparam int DW  = $clog2(DEBOUNCE_CYC + 1);
   localparam int HW  = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
   localparam int STW = (STAGGER_CYC > 1) ? $clog2(STAGGER_CYC) : 1;

   localparam logic [DW-1:0]  DEB_LAST  = DW'(DEBOUNCE_CYC - 1);
   localparam logic [DW-1:0]  DEB_SAT   = DW'(DEBOUNCE_CYC);
   localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_CYC - 1);
   localparam logic [STW-1:0] STG_LAST  = STW'(STAGGER_CYC - 1);

   localparam logic [2:0] CAUSE_POR  = 3'd1;
   localparam logic [2:0] CAUSE_BTN  = 3'd2;
   localparam logic [2:0] CAUSE_SW   = 3'd3;
   localparam logic [2:0] CAUSE_WDOG = 3'd4;

   typedef enum logic [1:0] {
      ST_HOLD    = 2'd0,
      ST_RELEASE = 2'd1,
      ST_RUN     = 2'd2
   } state_t;

   state_t           state;
   logic [HW-1:0]    hold_cnt;
   logic [STW-1:0]   stg_cnt;
   logic [N_DOM-1:0] rst_out_r;
   logic             all_rel_r;
   logic [2:0]       cause_r;

   logic             req_meta;
   logic             req_s;
   logic [DW-1:0]    deb_cnt;
   logic             btn_evt;
   logic             wdog_evt;
   logic             any_req;
   logic [2:0]       req_cause;
   logic [N_DOM-1:0] rst_shift;
   logic             last_stage;

   // Two-flop synchronizer for the asynchronous push-button
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         req_meta <= 1'b0;
         req_s    <= 1'b0;
      end else begin
         req_meta <= bus.req_in;
         req_s    <= req_meta;
      end
   end

   // Counter saturates one past the firing value, so a long press fires only once
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         deb_cnt <= '0;
      end else if (!req_s) begin
         deb_cnt <= '0;
      end else if (deb_cnt != DEB_SAT) begin
         deb_cnt <= deb_cnt + DW'(1);
      end
   end

   assign btn_evt = req_s && (deb_cnt == DEB_LAST);

`ifdef RST_WDOG_EN
   localparam int WW = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;
   localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYC - 1);

   logic [WW-1:0] wdog_cnt;

   // Runs only in RUN; outside RUN it is held at zero, which also clears it on exit
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wdog_cnt <= '0;
      end else if ((state != ST_RUN) || bus.wdog_kick || wdog_evt) begin
         wdog_cnt <= '0;
      end else begin
         wdog_cnt <= wdog_cnt + WW'(1);
      end
   end

   assign wdog_evt = (state == ST_RUN) && !bus.wdog_kick && (wdog_cnt == WDOG_LAST);
`else
   logic unused_wdog;
   assign unused_wdog = bus.wdog_kick ^ (WDOG_CYC == 0);
   assign wdog_evt    = 1'b0;
`endif

   assign any_req = btn_evt | bus.sw_req | wdog_evt;

   // When several requests land on the same edge, the button wins, then software
   always_comb begin
      req_cause = CAUSE_WDOG;
      if (btn_evt) begin
         req_cause = CAUSE_BTN;
      end else if (bus.sw_req) begin
         req_cause = CAUSE_SW;
      end
   end

   // rst_out is a thermometer code: a left shift releases the next domain up
   assign rst_shift  = rst_out_r << 1;
   assign last_stage = (rst_shift == '0);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= ST_HOLD;
         hold_cnt  <= '0;
         stg_cnt   <= '0;
         rst_out_r <= '1;
         all_rel_r <= 1'b0;
         cause_r   <= CAUSE_POR;
      end else if (any_req) begin
         state     <= ST_HOLD;
         hold_cnt  <= '0;
         stg_cnt   <= '0;
         rst_out_r <= '1;
         all_rel_r <= 1'b0;
         cause_r   <= req_cause;
      end else begin
         case (state)
            ST_HOLD: begin
               if (req_s) begin
                  hold_cnt <= '0;
               end else if (hold_cnt == HOLD_LAST) begin
                  hold_cnt  <= '0;
                  stg_cnt   <= '0;
                  rst_out_r <= rst_shift;
                  if (last_stage) begin
                     state     <= ST_RUN;
                     all_rel_r <= 1'b1;
                  end else begin
                     state <= ST_RELEASE;
                  end
               end else begin
                  hold_cnt <= hold_cnt + HW'(1);
               end
            end
            ST_RELEASE: begin
               if (stg_cnt == STG_LAST) begin
                  stg_cnt   <= '0;
                  rst_out_r <= rst_shift;
                  if (last_stage) begin
                     state     <= ST_RUN;
                     all_rel_r <= 1'b1;
                  end
               end else begin
                  stg_cnt <= stg_cnt + STW'(1);
               end
            end
            ST_RUN: begin
               rst_out_r <= '0;
               all_rel_r <= 1'b1;
            end
            default: begin
               state     <= ST_HOLD;
               hold_cnt  <= '0;
               stg_cnt   <= '0;
               rst_out_r <= '1;
               all_rel_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rst_out      = rst_out_r;
   assign bus.all_released = all_rel_r;
   assign bus.cause        = cause_r;
   assign bus.state_dbg    = state;

endmodule

// File: tb/tb_rst_sequencer.sv
// Randomized bench for rst_sequencer, checked cycle by cycle against a timeline reference model.
// The model turns time since the start of hold into the number of domains released.
module tb_rst_sequencer;
   localparam int N    = 3;
   localparam int DEB  = 16;
   localparam int HOLD = 64;
   localparam int STAG = 8;
   localparam int WDOG = 1024;
   localparam int W    = N + 6;

   logic clock;
   logic reset;

   rst_sequencer_if #(.N_DOM(N)) bus ();

   rst_sequencer #(
      .N_DOM(N), .DEBOUNCE_CYC(DEB), .HOLD_CYC(HOLD),
      .STAGGER_CYC(STAG), .WDOG_CYC(WDOG)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int tests = 0;
   int fails = 0;
   logic [W-1:0] exp_q[$];

   // Reference model: prog counts edges since hold began; the release count follows from it
   int   prog;
   int   run_len;
   int   edge_n;
   logic hist1, hist2;
   logic [2:0] m_cause;
`ifdef RST_WDOG_EN
   int   run_ref;
`endif

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int n_rel(input int p);
      int r;
      if (p < HOLD) return 0;
      r = 1 + (p - HOLD) / STAG;
      return (r > N) ? N : r;
   endfunction

   function automatic logic [N-1:0] rst_mask(input int n);
      logic [N-1:0] m;
      m = '1;
      for (int i = 0; i < n; i++) m[i] = 1'b0;
      return m;
   endfunction

   task automatic model_reset();
      prog    = 0;
      run_len = 0;
      hist1   = 1'b0;
      hist2   = 1'b0;
      m_cause = 3'd1;
      exp_q.delete();
   endtask

   task automatic model_step();
      logic req_s, btn, wd, was_run;
      logic [W-1:0] e;
      int n_before, n;
      edge_n++;
      req_s    = hist2;
      n_before = n_rel(prog);
      was_run  = (n_before == N);
      if (req_s) begin
         if (run_len < 1000) run_len++;
      end else begin
         run_len = 0;
      end
      btn = req_s && (run_len == DEB);
      wd  = 1'b0;
`ifdef RST_WDOG_EN
      if (was_run && !bus.wdog_kick && (edge_n - run_ref == WDOG)) wd = 1'b1;
      if (was_run && bus.wdog_kick) run_ref = edge_n;
`endif
      hist2 = hist1;
      hist1 = bus.req_in;
      if (btn || bus.sw_req || wd) begin
         prog    = 0;
         m_cause = btn ? 3'd2 : (bus.sw_req ? 3'd3 : 3'd4);
      end else if (n_before == 0 && req_s) begin
         prog = 0;
      end else if (prog < 1000000) begin
         prog++;
      end
      n = n_rel(prog);
`ifdef RST_WDOG_EN
      if (!was_run && n == N) run_ref = edge_n;
`endif
      e[N-1:0]     = rst_mask(n);
      e[N]         = (n == N);
      e[N+3:N+1]   = m_cause;
      e[N+5:N+4]   = (n == 0) ? 2'd0 : ((n < N) ? 2'd1 : 2'd2);
      exp_q.push_back(e);
   endtask

   task automatic score();
      logic [W-1:0] e;
      if (exp_q.size() == 0) begin
         check("exp_q_empty", 32'd0, 32'd1);
         return;
      end
      e = exp_q.pop_front();
      check("rst_out", 32'(bus.rst_out), 32'(e[N-1:0]));
      check("all_released", 32'(bus.all_released), 32'(e[N]));
      check("cause", 32'(bus.cause), 32'(e[N+3:N+1]));
      check("state_dbg", 32'(bus.state_dbg), 32'(e[N+5:N+4]));
   endtask

   task automatic cycle();
      @(posedge clock);
      if (!reset) model_step();
      #1;
      if (!reset) score();
   endtask

   task automatic drive(input logic r, input logic s, input logic k);
      bus.req_in    = r;
      bus.sw_req    = s;
      bus.wdog_kick = k;
   endtask

   // Asserted mid-cycle: outputs must respond with no clock edge
   task automatic do_reset(input int cycles);
      #3;
      reset = 1'b1;
      #1;
      check("async_rst_out", 32'(bus.rst_out), 32'(rst_mask(0)));
      check("async_all_rel", 32'(bus.all_released), 32'd0);
      check("async_cause", 32'(bus.cause), 32'd1);
      model_reset();
      repeat (cycles) cycle();
      #3;
      reset = 1'b0;
   endtask

   task automatic wait_rel(input int n, input int max_cyc);
      int k;
      k = 0;
      while (n_rel(prog) != n && k < max_cyc) begin
         cycle();
         k++;
      end
      check("wait_rel", 32'(bus.rst_out), 32'(rst_mask(n)));
   endtask

   task automatic sw_pulse();
      bus.sw_req = 1'b1;
      cycle();
      bus.sw_req = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      edge_n = 0;
`ifdef RST_WDOG_EN
      run_ref = 0;
`endif
      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b0);
      model_reset();

      // Power-on: 5 cycles of reset, then the 64/8/8 release sequence
      do_reset(5);
      repeat (90) cycle();
      check("por_cause", 32'(bus.cause), 32'd1);
      check("por_all_released", 32'(bus.all_released), 32'd1);

      // Bouncy presses shorter than the debounce window are ignored
      repeat (3) begin
         bus.req_in = 1'b1;
         repeat (10) cycle();
         bus.req_in = 1'b0;
         repeat (10) cycle();
      end
      repeat (5) cycle();
      check("bounce_rst_out", 32'(bus.rst_out), 32'd0);
      check("bounce_cause", 32'(bus.cause), 32'd1);

      // Held button
      bus.req_in = 1'b1;
      repeat (40) cycle();
      bus.req_in = 1'b0;
      repeat (100) cycle();
      check("held_cause", 32'(bus.cause), 32'd2);

      // Software request one cycle after domain 0 leaves reset
      sw_pulse();
      wait_rel(1, 200);
      cycle();
      sw_pulse();
      check("sw_release_rst", 32'(bus.rst_out), 32'(rst_mask(0)));
      check("sw_release_cause", 32'(bus.cause), 32'd3);
      repeat (90) cycle();

      // Software request on the same edge as the debounced button event
      bus.req_in = 1'b1;
      repeat (17) cycle();
      sw_pulse();
      check("coincide_cause", 32'(bus.cause), 32'd2);
      bus.req_in = 1'b0;
      repeat (100) cycle();

      // Reset in the middle of the release sequence
      sw_pulse();
      wait_rel(1, 200);
      do_reset(2);
      repeat (90) cycle();

`ifdef RST_WDOG_EN
      repeat (1100) cycle();
      check("wdog_cause", 32'(bus.cause), 32'd4);
      repeat (100) cycle();
      for (int i = 0; i < 3000; i++) begin
         bus.wdog_kick = (i % 1000 == 999);
         cycle();
      end
      bus.wdog_kick = 1'b0;
      check("kick_all_released", 32'(bus.all_released), 32'd1);
`else
      repeat (1100) cycle();
      check("no_wdog_all_released", 32'(bus.all_released), 32'd1);
      check("no_wdog_cause4", 32'(bus.cause == 3'd4), 32'd0);
`endif

      // Random traffic: button levels of random length, sparse sw pulses, kicks, resets
      for (int blk = 0; blk < 200; blk++) begin
         int len;
         logic lvl;
         len = $urandom_range(1, 40);
         lvl = ($urandom_range(0, 2) == 0);
         for (int j = 0; j < len; j++) begin
            bus.req_in    = lvl;
            bus.sw_req    = ($urandom_range(0, 149) == 0);
            bus.wdog_kick = ($urandom_range(0, 3) == 0);
            cycle();
         end
         bus.sw_req = 1'b0;
         if ($urandom_range(0, 59) == 0) do_reset($urandom_range(1, 3));
      end
      drive(1'b0, 1'b0, 1'b0);
      repeat (120) cycle();
      check("final_all_released", 32'(bus.all_released), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
